// File: rtl/mem_bus_responder.sv
// mem_bus_responder: byte-serial bus target decoding on-chip RAM and a UART IO window (TX FIFO, RX holding register, status)
module mem_bus_responder #(
    parameter int RAM_AW         = 17,
    parameter int TX_DEPTH       = 8,
    parameter int IO_FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LVL   = CW'(TX_DEPTH);
    localparam logic [CW-1:0] ALMOST_LVL = CW'(TX_DEPTH - IO_FULL_MARGIN);

    logic [7:0]    ram [2**RAM_AW];
    logic [7:0]    tx_mem [TX_DEPTH];
    logic [7:0]    mem_din_q, mem_din_d, rx_byte_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          tx_overflow_q, tx_overflow_d, rx_full_q, rx_full_d;
    logic          io_sel, io_data, io_stat, ram_we, push_req, push, pop, tx_full, rx_rd, rx_cap;
    logic          unused_a;

    assign unused_a = ^mem_a[31:18];

    assign io_sel   = mem_a[17:16] == 2'b11;
    assign io_data  = io_sel && mem_a[15:0] == 16'h0000;
    assign io_stat  = io_sel && mem_a[15:0] == 16'h0004;
    assign ram_we   = rdy_in && !io_sel && mem_wr;
    assign tx_full  = count_q == FULL_LVL;
    assign pop      = tx_valid && tx_ready;
    assign push_req = rdy_in && mem_wr && io_data;
    assign push     = push_req && (!tx_full || pop);
    assign rx_rd    = rdy_in && !mem_wr && io_data;
    assign rx_cap   = rx_valid && !rx_full_q;

    assign mem_din        = mem_din_q;
    assign tx_data        = tx_mem[rd_ptr_q];
    assign tx_valid       = count_q != '0;
    assign io_buffer_full = count_q >= ALMOST_LVL;
    assign rx_ready       = !rx_full_q;

    // Next-state for read data, FIFO bookkeeping, overflow flag and RX holding flag
    always_comb begin
        count_d       = count_q + CW'(push) - CW'(pop);
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        tx_overflow_d = (push_req && tx_full && !pop) ? 1'b1 :
                        (rdy_in && mem_wr && io_stat) ? 1'b0 : tx_overflow_q;
        rx_full_d     = (rx_rd && rx_full_q) ? 1'b0 : rx_cap ? 1'b1 : rx_full_q;
        mem_din_d     = !rdy_in  ? mem_din_q :
                        mem_wr   ? 8'h00 :
                        io_data  ? (rx_full_q ? rx_byte_q : 8'h00) :
                        io_stat  ? {5'b0, tx_overflow_q, rx_full_q, !tx_valid} :
                        io_sel   ? 8'h00 : ram[mem_a[RAM_AW-1:0]];
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tx_overflow_q <= 1'b0;
            rx_full_q     <= 1'b0;
        end else begin
            mem_din_q     <= mem_din_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tx_overflow_q <= tx_overflow_d;
            rx_full_q     <= rx_full_d;
        end
    end

    // Storage arrays and RX byte; contents are not reset
    always_ff @(posedge clk_in) begin
        if (ram_we) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
        if (push) tx_mem[wr_ptr_q] <= mem_dout;
        if (rx_cap) rx_byte_q <= rx_data;
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed checks of RAM access, TX FIFO, RX register, status and async reset
module tb_mem_bus_responder;
    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b0, mem_wr = 1'b0;
    logic        tx_ready = 1'b0, rx_valid = 1'b0;
    logic [31:0] mem_a = '0;
    logic [7:0]  mem_dout = '0, rx_data = '0;
    logic [7:0]  mem_din, tx_data;
    logic        io_buffer_full, tx_valid, rx_ready;
    int          vectors = 0, miscompares = 0;
    logic [7:0]  drain_exp [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};

    mem_bus_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
        rdy_in = 1'b1; mem_wr = wr; mem_a = a; mem_dout = d;
        @(negedge clk_in);
        rdy_in = 1'b0; mem_wr = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        chk("rst_mem_din", mem_din, 8'h00);
        chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst_ibf", {7'b0, io_buffer_full}, 8'h00);
        chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        rst_in = 1'b0;

        bus(1'b1, 32'h10, 8'hA5);
        chk("wr_din_zero", mem_din, 8'h00);
        bus(1'b0, 32'h10, 8'h00);
        chk("rd_a5", mem_din, 8'hA5);

        bus(1'b1, 32'h0, 8'h13);
        bus(1'b1, 32'h1, 8'h00);
        bus(1'b1, 32'h2, 8'h00);
        bus(1'b1, 32'h3, 8'h00);
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, 32'(i), 8'h00);
            chk("burst_rd", mem_din, i == 0 ? 8'h13 : 8'h00);
        end

        bus(1'b1, 32'h20, 8'h77);
        bus(1'b0, 32'h20, 8'h00);
        chk("rd_77", mem_din, 8'h77);
        rdy_in = 1'b0; mem_wr = 1'b1; mem_a = 32'h20; mem_dout = 8'hFF;
        @(negedge clk_in);
        chk("rdy0_hold", mem_din, 8'h77);
        mem_a = 32'h30000;
        @(negedge clk_in);
        chk("rdy0_no_push", {7'b0, tx_valid}, 8'h00);
        mem_wr = 1'b0;
        bus(1'b0, 32'h20, 8'h00);
        chk("rdy0_ram_kept", mem_din, 8'h77);

        for (int i = 1; i <= 6; i++) begin
            bus(1'b1, 32'h30000, 8'(i));
            if (i == 5) chk("ibf_at5", {7'b0, io_buffer_full}, 8'h00);
        end
        chk("ibf_at6", {7'b0, io_buffer_full}, 8'h01);
        bus(1'b1, 32'h30000, 8'h07);
        bus(1'b1, 32'h30000, 8'h08);
        bus(1'b1, 32'h30000, 8'h99);
        bus(1'b0, 32'h30004, 8'h00);
        chk("status_ovf", mem_din, 8'h04);
        chk("tx_head", tx_data, 8'h01);

        tx_ready = 1'b1;
        bus(1'b1, 32'h30000, 8'h55);
        chk("full_pushpop_ibf", {7'b0, io_buffer_full}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {7'b0, tx_valid}, 8'h01);
            chk("drain_data", tx_data, drain_exp[i]);
            @(negedge clk_in);
        end
        chk("drained_valid", {7'b0, tx_valid}, 8'h00);
        chk("drained_ibf", {7'b0, io_buffer_full}, 8'h00);
        tx_ready = 1'b0;

        bus(1'b1, 32'h30004, 8'h00);
        bus(1'b0, 32'h30004, 8'h00);
        chk("status_clr", mem_din, 8'h01);
        bus(1'b1, 32'h30008, 8'hEE);
        bus(1'b0, 32'h30008, 8'h00);
        chk("other_io_rd", mem_din, 8'h00);
        chk("other_io_wr", {7'b0, tx_valid}, 8'h00);

        rx_data = 8'h3C; rx_valid = 1'b1;
        @(negedge clk_in);
        rx_valid = 1'b0;
        chk("rx_full", {7'b0, rx_ready}, 8'h00);
        bus(1'b0, 32'h30000, 8'h00);
        chk("rx_rd", mem_din, 8'h3C);
        chk("rx_freed", {7'b0, rx_ready}, 8'h01);
        bus(1'b0, 32'h30000, 8'h00);
        chk("rx_rd_empty", mem_din, 8'h00);

        rx_data = 8'h11; rx_valid = 1'b1;
        @(negedge clk_in);
        chk("rx_full2", {7'b0, rx_ready}, 8'h00);
        rx_data = 8'h22;
        bus(1'b0, 32'h30000, 8'h00);
        chk("clr_wins_data", mem_din, 8'h11);
        chk("clr_wins_ready", {7'b0, rx_ready}, 8'h01);
        @(negedge clk_in);
        rx_valid = 1'b0;
        chk("rx_next_cap", {7'b0, rx_ready}, 8'h00);
        bus(1'b0, 32'h30000, 8'h00);
        chk("rx_next_data", mem_din, 8'h22);

        for (int i = 0; i < 6; i++) bus(1'b1, 32'h30000, 8'(8'h40 + i));
        rx_data = 8'h5A; rx_valid = 1'b1;
        @(negedge clk_in);
        rx_valid = 1'b0;
        bus(1'b0, 32'h10, 8'h00);
        chk("pre_rst_din", mem_din, 8'hA5);
        chk("pre_rst_ibf", {7'b0, io_buffer_full}, 8'h01);
        chk("pre_rst_rx", {7'b0, rx_ready}, 8'h00);
        #2 rst_in = 1'b1;
        #1;
        chk("async_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("async_ibf", {7'b0, io_buffer_full}, 8'h00);
        chk("async_rx_ready", {7'b0, rx_ready}, 8'h01);
        chk("async_din", mem_din, 8'h00);
        @(negedge clk_in);
        rst_in = 1'b0;
        bus(1'b0, 32'h10, 8'h00);
        chk("ram_survives_rst", mem_din, 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
